// File: rtl/outstream_check_if.sv
// outstream_check_if: valid/acknowledge handshake between the node that
// drives a puzzle output port (master) and the output-stream checker (slave).
interface outstream_check_if #(
  parameter int WIDTH = 11
);
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ack;

  modport master (output in_valid, output in_data, input in_ack);
  modport slave  (input in_valid, input in_data, output in_ack);
endinterface

// File: rtl/outstream_check.sv
// outstream_check: captures an output stream into a buffer, compares each
// word against the expected stream and reports done/pass/error statistics.
// Optional idle watchdog enabled by defining OUTSTREAM_TIMEOUT_EN.
module outstream_check #(
  parameter int DEPTH   = 39,
  parameter int WIDTH   = 11,
  parameter int TIMEOUT = 1024
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [5:0]             length,
  input  logic [WIDTH*DEPTH-1:0] expected,
  outstream_check_if.slave       in_bus,
  output logic [WIDTH*DEPTH-1:0] result,
  output logic [5:0]             pos,
  output logic                   done,
  output logic                   pass,
  output logic                   mismatch,
  output logic [5:0]             err_count,
  output logic [5:0]             first_err,
  output logic                   overrun,
  output logic                   timeout
);

  // Buffer index and counters are 6 bits wide; a 0 watchdog limit is meaningless.
  if (DEPTH > 63 || TIMEOUT < 1) begin : g_param_check
    $error("outstream_check: DEPTH must be <= 63 and TIMEOUT >= 1");
  end

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [5:0] NO_ERR  = 6'h3F;

  logic [1:0]       state;
  logic [5:0]       len_q;
  logic             ack_q;
  logic [WIDTH-1:0] result_q [DEPTH];
  logic [WIDTH-1:0] exp_arr  [DEPTH];
  logic             timeout_q;

`ifdef OUTSTREAM_TIMEOUT_EN
  localparam int TIMEOUT_W = $clog2(TIMEOUT + 1);
  logic [TIMEOUT_W-1:0] idle_cnt;
`endif

  // Unpack the flat expected bus and pack the capture buffer onto result
  always_comb begin
    // NOTE: every always_comb output gets a value on every path (here by
    // the full loop) so no latch is inferred.
    for (int i = 0; i < DEPTH; i++) begin
      exp_arr[i]                 = expected[i*WIDTH +: WIDTH];
      result[i*WIDTH +: WIDTH]   = result_q[i];
    end
  end

  assign in_bus.in_ack = ack_q;
  assign done          = (state == ST_DONE);
  assign timeout       = timeout_q;
  assign pass          = done & ~mismatch & ~overrun & ~timeout_q;

  // Capture FSM, sticky status flags and the one-cycle acknowledge pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      len_q     <= '0;
      ack_q     <= 1'b0;
      pos       <= '0;
      mismatch  <= 1'b0;
      err_count <= '0;
      first_err <= NO_ERR;
      overrun   <= 1'b0;
      timeout_q <= 1'b0;
      // NOTE: the capture buffer is reset on purpose: result must read all
      // zeros after reset, so it is built from resettable flops, not RAM.
      for (int i = 0; i < DEPTH; i++) result_q[i] <= '0;
`ifdef OUTSTREAM_TIMEOUT_EN
      idle_cnt  <= '0;
`endif
    end else begin
      // NOTE: non-blocking assignments throughout so every register samples
      // pre-edge values regardless of statement order.
      ack_q <= 1'b0;
      case (state)
        ST_RUN: begin
          if (in_bus.in_valid && !ack_q) begin
            result_q[pos] <= in_bus.in_data;
            pos           <= pos + 6'd1;
            ack_q         <= 1'b1;
            if ($signed(in_bus.in_data) != $signed(exp_arr[pos])) begin
              mismatch <= 1'b1;
              if (err_count != 6'h3F) err_count <= err_count + 6'd1;
              if (first_err == NO_ERR) first_err <= pos;
            end
            if (pos == len_q - 6'd1) state <= ST_DONE;
`ifdef OUTSTREAM_TIMEOUT_EN
            idle_cnt <= '0;
          end else if (idle_cnt == TIMEOUT_W'(TIMEOUT - 1)) begin
            // Limit-th consecutive idle cycle: give up on the producer
            timeout_q <= 1'b1;
            state     <= ST_DONE;
          end else begin
            idle_cnt <= idle_cnt + 1'b1;
`endif
          end
        end
        default: begin
          // IDLE and DONE both (re-)arm on start; result is kept on purpose
          if (start) begin
            len_q     <= length;
            pos       <= '0;
            mismatch  <= 1'b0;
            err_count <= '0;
            first_err <= NO_ERR;
            overrun   <= 1'b0;
            timeout_q <= 1'b0;
            state     <= (length == 6'd0) ? ST_DONE : ST_RUN;
`ifdef OUTSTREAM_TIMEOUT_EN
            idle_cnt  <= '0;
`endif
          end else if (state == ST_DONE && in_bus.in_valid && !ack_q) begin
            // Extra word after the stream ended: swallow it, never stall
            ack_q   <= 1'b1;
            overrun <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: doc/outstream_check.md
# outstream_check

Output-stream capture and checker for the FPGA test harness. Sits directly downstream of the node that drives a puzzle output port: it accepts values over a valid/acknowledge handshake, stores them in a capture buffer, and compares each against the expected output stream. When the stream completes it reports done, pass/fail and error statistics to the harness controller.

## Interface
Parameters:
- `DEPTH`, 39: capture/expected buffer entries; `length` never exceeds this.
- `WIDTH`, 11: signed data word width.
- `TIMEOUT`, 1024: idle-cycle limit. Used only with `OUTSTREAM_TIMEOUT_EN`.

Ports:
- `clk`  in  1: single clock; all logic on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `start`  in  1: arms a capture run; samples `length`.
- `length`  in  6: number of expected values, 0..DEPTH.
- `expected`  in  WIDTH×DEPTH: signed expected values, index 0 first.
- `in_valid`  in  1: producer has a word on `in_data`; held until acknowledged.
- `in_data`  in  WIDTH: signed producer word.
- `in_ack`  out  1: one-cycle registered acknowledge pulse.
- `result`  out  WIDTH×DEPTH: captured values.
- `pos`  out  6: number of values captured this run.
- `done`  out  1: run complete.
- `pass`  out  1: combinational; `done & ~mismatch & ~overrun & ~timeout`.
- `mismatch`  out  1: sticky; at least one compare failed.
- `err_count`  out  6: number of failed compares, saturating at 63.
- `first_err`  out  6: index of the first failed compare; 6'h3F if none.
- `overrun`  out  1: sticky; a value arrived after `length` values.
- `timeout`  out  1: sticky watchdog flag; constant 0 without the macro.

## Operation
- States: IDLE, RUN, DONE.
- Reset values: state IDLE, all other outputs 0 (including `result` entries and `pos`), except `first_err` = 6'h3F.
- IDLE, `start`=1:
  - latch `length`.
  - If `length`=0, go to DONE; otherwise go to RUN.
  - Clear `pos`, `mismatch`, `err_count`, `overrun` and `timeout`; set `first_err` to 6'h3F.
  - `result` is not cleared.
- DONE, `start`=1: same as IDLE (re-arm).
- RUN: `start` is ignored.
- Capture (RUN, `in_valid`=1, `in_ack`=0):
  - `result[pos]` <= `in_data`; `pos` <= `pos`+1; `in_ack` <= 1.
  - If `in_data` != `expected[pos]` (full-width signed compare): set `mismatch`, increment `err_count` (saturating at 63), and load `first_err` <= `pos` if it is still 6'h3F.
  - If `pos` = latched length−1: go to DONE.
- `in_valid` is ignored while `in_ack`=1, so a held word is never captured twice. The producer drops or changes `in_valid`/`in_data` in the cycle after it sees `in_ack`.
- DONE, `in_valid`=1, `in_ack`=0: acknowledge the word, set `overrun`, and leave `result` and `pos` unchanged. The producer is never stalled.
- IDLE: `in_valid` is not acknowledged; the producer stalls.
- `rst_n` low at any time, including mid-RUN: asynchronous return to reset values.

## Timing
- `start` sampled at edge N: state is RUN (or DONE when `length`=0) after edge N.
- Capture latency: `in_valid` seen at edge N. After edge N: `result`, `pos`, flags updated and `in_ack`=1. After edge N+1: `in_ack`=0. Next capture possible at edge N+2.
- Maximum throughput: one word per 2 cycles.
- `done` rises at the edge that captures the final word, together with that word's `in_ack`.
- `pass` settles in the same cycle as `done`.

## Configuration
- Macro `OUTSTREAM_TIMEOUT_EN`.
- Defined:
  - A counter increments each RUN cycle without a capture and clears on each capture and on `start`.
  - When the counter reaches `TIMEOUT`: set `timeout` and go to DONE.
- Not defined: no counter; `timeout` tied to 0; RUN waits indefinitely.

## Test plan
- `length`=3, `expected`={5,−7,999}; producer sends 5, −7, 999, each held until `in_ack` → 3 `in_ack` pulses, `pos` 0→3, `done` with the 3rd ack, `pass`=1, `err_count`=0, `first_err`=6'h3F.
- Same setup, producer sends 5, −6, 998 → `mismatch`=1, `err_count`=2, `first_err`=1, `pass`=0, `result`={5,−6,998}.
- `length`=0, `start` → `done`=1 and `pass`=1 one cycle later; `in_ack` stays 0 when `in_valid`=0.
- After `done` with `length`=1, send 42 → `in_ack` pulse, `overrun`=1, `pass`=0, `pos`=1, `result[0]` unchanged.
- `in_valid` held high with value 7 for 6 cycles, `length`=4 → exactly 3 captures on alternate cycles, `pos`=3, `done`=0; then `rst_n` low → all outputs at reset values immediately, without waiting for a clock edge.
- With `OUTSTREAM_TIMEOUT_EN` and `TIMEOUT`=16, `length`=2, one word then no `in_valid` for 16 cycles → `timeout`=1, `done`=1, `pass`=0, `pos`=1.
